// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
//   Shared types and constants for the tagged memory interface.
//
//   ADDR            32-bit byte address
//   MEM_BLOCK       64-bit memory block
//   MEM_TAG         4-bit transaction tag (0 = no transaction)
//   MEM_COMMAND     MEM_NONE / MEM_LOAD / MEM_STORE
//   MEM_RESP_ENTRY  one response pipeline stage (valid, tag, data)
//
//   Helper functions:
//   lowest_free_tag  priority encoder over the free mask (tag 1 = bit 0)
//   lfsr_step        16-bit maximal-length Galois-free (Fibonacci, right
//                    shift) LFSR step, taps 16/14/13/11
// -----------------------------------------------------------------------------
package mem_responder_pkg;

    typedef logic [31:0] ADDR;
    typedef logic [63:0] MEM_BLOCK;
    typedef logic [3:0]  MEM_TAG;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef struct packed {
        logic     valid;
        MEM_TAG   tag;
        MEM_BLOCK data;
    } MEM_RESP_ENTRY;

    localparam int          MEM_NUM_TAGS        = 15;
    localparam int          MEM_LATENCY_DEFAULT = 4;
    localparam logic [15:0] MEM_LFSR_SEED       = 16'hACE1;

    // Bit i of the mask stands for tag i+1; returns 0 when nothing is free.
    function automatic MEM_TAG lowest_free_tag(input logic [MEM_NUM_TAGS-1:0] free_mask);
        MEM_TAG tag;
        tag = '0;
        for (int i = MEM_NUM_TAGS - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                tag = MEM_TAG'(i + 1);
            end
        end
        return tag;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/mem_tag_allocator.sv
// -----------------------------------------------------------------------------
// mem_tag_allocator
//   Holds the free mask for the 15 transaction tags (1..15) and hands out the
//   lowest-numbered free tag. A tag freed in a cycle only returns to the mask
//   at the next edge, so it cannot be reallocated in the cycle it is freed.
//
//   Ports:
//   clock       in   sole clock
//   reset       in   synchronous active-low reset (mask -> all free)
//   alloc_req   in   consume alloc_tag at the next edge (ignored when full)
//   free_valid  in   return free_tag to the mask at the next edge
//   free_tag    in   tag being returned (0 is ignored)
//   alloc_tag   out  lowest free tag, 0 when none is free
//   full        out  no tag is free
// -----------------------------------------------------------------------------
module mem_tag_allocator
    import mem_responder_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   alloc_req,
    input  logic   free_valid,
    input  MEM_TAG free_tag,
    output MEM_TAG alloc_tag,
    output logic   full
);

    logic [MEM_NUM_TAGS-1:0] free_mask;
    logic [MEM_NUM_TAGS-1:0] free_mask_next;

    // Encoding looks only at the registered mask: this is what keeps a tag
    // freed this cycle out of reach until the following cycle.
    assign alloc_tag = lowest_free_tag(free_mask);
    assign full      = ~|free_mask;

    always_comb begin
        free_mask_next = free_mask;
        if (free_valid && (free_tag != '0)) begin
            free_mask_next[free_tag - MEM_TAG'(1)] = 1'b1;
        end
        if (alloc_req && !full) begin
            free_mask_next[alloc_tag - MEM_TAG'(1)] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            free_mask <= '1;
        end else begin
            free_mask <= free_mask_next;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the tagged memory interface. Loads are given a
//   nonzero tag in the cycle they are accepted; the 64-bit block read in that
//   cycle comes back with the same tag exactly MEM_LATENCY cycles later.
//   Stores write the backing store at the end of their cycle. Store contents
//   are not touched by reset.
//
//   Parameters:
//   MEM_LATENCY        cycles from load acceptance to data return (1..32)
//   MEM_DEPTH_BLOCKS   number of 64-bit blocks in the store (power of two)
//
//   Optional build macro:
//   MEM_STALL_INJECT_EN  when defined, a 16-bit LFSR (seed 16'hACE1) rejects
//                        loads in cycles where its low 3 bits are zero.
//
//   Ports:
//   clock                     in   sole clock
//   reset                     in   synchronous active-low reset
//   proc2mem_command          in   MEM_NONE / MEM_LOAD / MEM_STORE
//   proc2mem_addr             in   byte address, bits [2:0] ignored
//   proc2mem_data             in   store data
//   mem2proc_transaction_tag  out  combinational; nonzero = load accepted
//   mem2proc_data             out  returned block, 0 when no response
//   mem2proc_data_tag         out  tag of the load answered this cycle, or 0
// -----------------------------------------------------------------------------
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_LATENCY      = MEM_LATENCY_DEFAULT,
    parameter int MEM_DEPTH_BLOCKS = 8192
)
(
    input  logic       clock,
    input  logic       reset,
    input  MEM_COMMAND proc2mem_command,
    input  ADDR        proc2mem_addr,
    input  MEM_BLOCK   proc2mem_data,
    output MEM_TAG     mem2proc_transaction_tag,
    output MEM_BLOCK   mem2proc_data,
    output MEM_TAG     mem2proc_data_tag
);

    localparam int IDX_W = $clog2(MEM_DEPTH_BLOCKS);

    MEM_BLOCK      mem [MEM_DEPTH_BLOCKS];
    MEM_RESP_ENTRY pipe [MEM_LATENCY];
    MEM_RESP_ENTRY out_stage;

    logic [28:0]      blk_addr;
    logic [IDX_W-1:0] blk_idx;
    logic             in_range;
    logic             stall;
    logic             load_accept;
    logic             store_en;
    logic             tags_full;
    logic             resp_valid;
    MEM_TAG           alloc_tag;
    MEM_BLOCK         rd_data;
    logic             addr_unused;

    assign addr_unused = ^proc2mem_addr[2:0];

    assign blk_addr = proc2mem_addr[31:3];
    assign blk_idx  = blk_addr[IDX_W-1:0];
    assign in_range = ({3'b000, blk_addr} < 32'(MEM_DEPTH_BLOCKS));

`ifdef MEM_STALL_INJECT_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr <= MEM_LFSR_SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    assign stall = (lfsr[2:0] == 3'b000);
`else
    assign stall = 1'b0;
`endif

    assign load_accept = reset && (proc2mem_command == MEM_LOAD) && in_range
                         && !tags_full && !stall;
    assign store_en    = reset && (proc2mem_command == MEM_STORE) && in_range;

    assign mem2proc_transaction_tag = load_accept ? alloc_tag : '0;

    // Read in the acceptance cycle, so a store from the previous cycle is seen.
    assign rd_data = load_accept ? mem[blk_idx] : '0;

    always_ff @(posedge clock) begin
        if (store_en) begin
            mem[blk_idx] <= proc2mem_data;
        end
    end

    // Stage 0 holds a load accepted last cycle; stage MEM_LATENCY-1 is the
    // output, so a load accepted in cycle t is presented in cycle t+MEM_LATENCY.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: load_accept, tag: mem2proc_transaction_tag, data: rd_data};
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign out_stage  = pipe[MEM_LATENCY-1];
    // Gating with reset keeps the outputs quiet in the cycle reset is first
    // sampled, before the pipeline has actually been cleared.
    assign resp_valid = out_stage.valid && reset;

    assign mem2proc_data     = resp_valid ? out_stage.data : '0;
    assign mem2proc_data_tag = resp_valid ? out_stage.tag  : '0;

    mem_tag_allocator u_tag_alloc (
        .clock      (clock),
        .reset      (reset),
        .alloc_req  (load_accept),
        .free_valid (resp_valid),
        .free_tag   (out_stage.tag),
        .alloc_tag  (alloc_tag),
        .full       (tags_full)
    );

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int N    = 2;
    localparam int LAT0 = 4;
    localparam int LAT1 = 20;
    localparam int DEP0 = 8192;
    localparam int DEP1 = 256;

    logic       clock;
    logic       rst   [N];
    MEM_COMMAND cmd   [N];
    ADDR        addr  [N];
    MEM_BLOCK   wdata [N];
    MEM_TAG     ttag  [N];
    MEM_BLOCK   rdata [N];
    MEM_TAG     rtag  [N];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mem_responder #(.MEM_LATENCY(LAT0), .MEM_DEPTH_BLOCKS(DEP0)) dut0 (
        .clock(clock), .reset(rst[0]), .proc2mem_command(cmd[0]),
        .proc2mem_addr(addr[0]), .proc2mem_data(wdata[0]),
        .mem2proc_transaction_tag(ttag[0]), .mem2proc_data(rdata[0]),
        .mem2proc_data_tag(rtag[0]));

    mem_responder #(.MEM_LATENCY(LAT1), .MEM_DEPTH_BLOCKS(DEP1)) dut1 (
        .clock(clock), .reset(rst[1]), .proc2mem_command(cmd[1]),
        .proc2mem_addr(addr[1]), .proc2mem_data(wdata[1]),
        .mem2proc_transaction_tag(ttag[1]), .mem2proc_data(rdata[1]),
        .mem2proc_data_tag(rtag[1]));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    function automatic int lat_of(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int dep_of(input int k);
        return (k == 0) ? DEP0 : DEP1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          k;
        int          due;
        int          tag;
        logic [63:0] data;
    } resp_t;

    resp_t       rq [$];
    bit [15:1]   fm [N];
    logic [15:0] lf [N];
    logic [63:0] mm [int];

    task automatic model_step(input int k);
        int          pos;
        int          exp_t;
        int          exp_rt;
        logic [63:0] exp_d;
        int          blk;
        int          key;
        bit          inr;
        bit          stall;
        resp_t       keep [$];
        pos    = -1;
        exp_t  = 0;
        exp_rt = 0;
        exp_d  = '0;
        foreach (rq[i]) begin
            if (rq[i].k == k && pos < 0) pos = i;
        end
        if (rst[k] == 1'b0) begin
            check("rst_ttag", 64'(ttag[k]), 64'd0);
            check("rst_rtag", 64'(rtag[k]), 64'd0);
            check("rst_rdata", rdata[k], 64'd0);
            fm[k] = '1;
            lf[k] = 16'hACE1;
            foreach (rq[i]) begin
                if (rq[i].k != k) keep.push_back(rq[i]);
            end
            rq = keep;
            return;
        end
        if (pos >= 0 && rq[pos].due == cyc) begin
            exp_rt = rq[pos].tag;
            exp_d  = rq[pos].data;
        end
        blk   = int'(addr[k][31:3]);
        inr   = (blk < dep_of(k));
        key   = k * 65536 + blk;
        stall = 1'b0;
`ifdef MEM_STALL_INJECT_EN
        stall = (lf[k][2:0] == 3'b000);
`endif
        if (cmd[k] == MEM_LOAD && inr && !stall) begin
            for (int t = 1; t <= 15; t++) begin
                if (exp_t == 0 && fm[k][t]) exp_t = t;
            end
        end
        check("ttag", 64'(ttag[k]), 64'(exp_t));
        check("rtag", 64'(rtag[k]), 64'(exp_rt));
        check("rdata", rdata[k], exp_d);
        if (exp_rt != 0) begin
            fm[k][exp_rt] = 1'b1;
            rq.delete(pos);
        end
        if (exp_t != 0) begin
            fm[k][exp_t] = 1'b0;
            rq.push_back('{k, cyc + lat_of(k), exp_t, mm.exists(key) ? mm[key] : 64'd0});
        end
        if (cmd[k] == MEM_STORE && inr) mm[key] = wdata[k];
        lf[k] = {lf[k][0] ^ lf[k][2] ^ lf[k][3] ^ lf[k][5], lf[k][15:1]};
    endtask

    always @(negedge clock) begin
        for (int k = 0; k < N; k++) model_step(k);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int k, input MEM_COMMAND c, input ADDR a, input MEM_BLOCK d);
        cmd[k]   = c;
        addr[k]  = a;
        wdata[k] = d;
    endtask

    task automatic idle_all();
        for (int k = 0; k < N; k++) drive(k, MEM_NONE, '0, '0);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b0;
            drive(k, MEM_NONE, '0, '0);
        end
        tick();
        tick();
        for (int k = 0; k < N; k++) rst[k] = 1'b1;
        @(negedge clock);
        check("post_rst_rtag0", 64'(rtag[0]), 64'd0);
        check("post_rst_rdata0", rdata[0], 64'd0);
        tick();

        // Preload blocks 0..31 of both stores plus the last in-range block.
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < N; k++) begin
                drive(k, MEM_STORE, ADDR'(i * 8), {$urandom, $urandom});
            end
            if (i == 2) wdata[0] = 64'hDEAD_BEEF_0123_4567;
            tick();
        end
        drive(0, MEM_STORE, ADDR'((DEP0 - 1) * 8), {$urandom, $urandom});
        drive(1, MEM_STORE, ADDR'((DEP1 - 1) * 8), {$urandom, $urandom});
        tick();
        idle_all();
        tick();

`ifndef MEM_STALL_INJECT_EN
        // Single load of block 2, latency 4.
        drive(0, MEM_LOAD, 32'h0000_0010, '0);
        @(negedge clock);
        check("t1_ttag", 64'(ttag[0]), 64'd1);
        tick();
        idle_all();
        tick();
        tick();
        @(negedge clock);
        check("t1_rtag_t3", 64'(rtag[0]), 64'd0);
        tick();
        @(negedge clock);
        check("t1_rtag_t4", 64'(rtag[0]), 64'd1);
        check("t1_rdata_t4", rdata[0], 64'hDEAD_BEEF_0123_4567);
        tick();
        @(negedge clock);
        check("t1_rtag_t5", 64'(rtag[0]), 64'd0);
        tick();

        // Tag exhaustion with latency 20; tag 1 reissued one cycle after its return.
        for (int i = 0; i <= 21; i++) begin
            drive(1, MEM_LOAD, ADDR'((i % 32) * 8), '0);
            @(negedge clock);
            if (i < 15)       check("t2_ttag_seq", 64'(ttag[1]), 64'(i + 1));
            else if (i < 21)  check("t2_ttag_full", 64'(ttag[1]), 64'd0);
            else              check("t2_ttag_reuse", 64'(ttag[1]), 64'd1);
            if (i == 20) check("t2_rtag_first", 64'(rtag[1]), 64'd1);
            tick();
        end
        idle_all();
        repeat (40) tick();

        // Store then load of the same block.
        drive(0, MEM_STORE, 32'h0000_0040, 64'h1);
        @(negedge clock);
        check("t3_store_ttag", 64'(ttag[0]), 64'd0);
        tick();
        drive(0, MEM_LOAD, 32'h0000_0040, '0);
        @(negedge clock);
        check("t3_load_ttag", 64'(ttag[0]), 64'd1);
        tick();
        idle_all();
        repeat (3) tick();
        @(negedge clock);
        check("t3_rtag", 64'(rtag[0]), 64'd1);
        check("t3_rdata", rdata[0], 64'h1);
        tick();

        // Out-of-range loads, and the last in-range block.
        drive(0, MEM_LOAD, ADDR'(DEP0 * 8), '0);
        drive(1, MEM_LOAD, ADDR'(DEP1 * 8), '0);
        @(negedge clock);
        check("t4_oob_ttag0", 64'(ttag[0]), 64'd0);
        check("t4_oob_ttag1", 64'(ttag[1]), 64'd0);
        tick();
        idle_all();
        drive(1, MEM_LOAD, ADDR'((DEP1 - 1) * 8), '0);
        @(negedge clock);
        check("t4_last_ttag1", 64'(ttag[1]), 64'd1);
        tick();
        idle_all();
        repeat (25) tick();

        // Reset while three loads are in flight.
        for (int i = 0; i < 3; i++) begin
            drive(0, MEM_LOAD, ADDR'((i + 4) * 8), '0);
            @(negedge clock);
            check("t5_ttag", 64'(ttag[0]), 64'(i + 1));
            tick();
        end
        rst[0] = 1'b0;
        drive(0, MEM_LOAD, 32'h0000_0020, '0);
        @(negedge clock);
        check("t5_rst_ttag", 64'(ttag[0]), 64'd0);
        tick();
        rst[0] = 1'b1;
        idle_all();
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("t5_quiet_rtag", 64'(rtag[0]), 64'd0);
            tick();
        end
        drive(0, MEM_LOAD, 32'h0000_0018, '0);
        @(negedge clock);
        check("t5_after_rst_ttag", 64'(ttag[0]), 64'd1);
        tick();
        idle_all();
        repeat (6) tick();
`endif

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < N; k++) begin
                int r;
                int blk;
                r = $urandom_range(0, 99);
                rst[k] = (r == 0) ? 1'b0 : 1'b1;
                if ($urandom_range(0, 15) == 0) blk = dep_of(k) + $urandom_range(0, 3);
                else                           blk = $urandom_range(0, 31);
                r = $urandom_range(0, 99);
                if (r < 55)      drive(k, MEM_LOAD,  ADDR'(blk * 8 + $urandom_range(0, 7)), '0);
                else if (r < 75) drive(k, MEM_STORE, ADDR'(blk * 8), {$urandom, $urandom});
                else             drive(k, MEM_NONE,  ADDR'(blk * 8), '0);
            end
            tick();
        end
        for (int k = 0; k < N; k++) rst[k] = 1'b1;
        idle_all();
        repeat (30) tick();
        @(negedge clock);
        check("drain_pending", 64'(rq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
